sm_tri_bus_port: RTL and testbench
==================================

// Module: sm_tri_bus_port
//
// PURPOSE
//   Half-duplex endpoint on a shared tristate bus. Drives the bus through
//   sm_Buf on the transmit side and samples it on the receive side.
//   Local logic sends messages with val/rdy; an external arbiter grants
//   bus ownership. Messages addressed to p_id are queued for local logic.
//   One instance per bus agent; agents share bus_val/bus_dst/bus_data.
//
// PARAMETERS
//   p_nbits   8   width of bus_data / message payload
//   p_idbits  2   width of agent id / bus_dst field
//   p_id      0   this agent's address; RX accepts only bus_dst == p_id
//
// PORTS
//   clk       in     1          clock, all state updates on posedge
//   reset     in     1          synchronous, active-high
//   tx_val    in     1          local message valid
//   tx_rdy    out    1          port can accept a message
//   tx_dst    in     p_idbits   destination id of tx message
//   tx_msg    in     p_nbits    tx payload
//   arb_req   out    1          bus request to external arbiter
//   arb_gnt   in     1          bus grant from arbiter (one agent at a time)
//   bus_val   inout  1          shared valid (tri; board/bench pull-down)
//   bus_dst   inout  p_idbits   shared destination id (tri)
//   bus_data  inout  p_nbits    shared payload (tri)
//   rx_val    out    1          received message available
//   rx_rdy    in     1          local logic consumes rx message
//   rx_msg    out    p_nbits    head of RX queue
//   rx_drops  out    8          saturating count of dropped RX messages
//
// BEHAVIOUR
//   Clocking: one clock; reset is synchronous and active-high.
//   Reset: state=IDLE, tx_rdy=1, arb_req=0, bus drivers off (all bus pins z),
//     RX queue empty (rx_val=0), rx_drops=0. Reset mid-DRIVE releases bus
//     on the next edge and discards the held message.
//   TX FSM:
//     IDLE : tx_rdy=1. tx_val&tx_rdy -> latch {tx_dst,tx_msg}, go REQ.
//     REQ  : tx_rdy=0, arb_req=1. arb_gnt=1 -> DRIVE; else stay.
//     DRIVE: exactly one cycle; drv_en=1, bus_val=1, bus_dst/bus_data = held
//            values; arb_req=1. -> TURN unconditionally.
//     TURN : drv_en=0, arb_req=0 (bus turnaround cycle). -> IDLE.
//   arb_gnt is ignored outside REQ. Min TX period 4 cycles; msg appears on
//     bus 2 cycles after acceptance if granted immediately.
//   Drivers: three sm_Buf instances (1, p_idbits, p_nbits) share drv_en;
//     drv_en is a registered decode of state==DRIVE (no glitches).
//   RX: push when bus_val==1 && bus_dst==p_id && state!=DRIVE (no self-rx).
//     Queue is 2 entries, in-order; rx_val = !empty, rx_msg = head;
//     pop when rx_val&rx_rdy. Latency bus->rx_val: 1 cycle.
//   Full queue: push with simultaneous pop is accepted; push without pop
//     is dropped and rx_drops increments, saturating at 255.
//   Empty queue: push is visible next cycle (no same-cycle bypass).
//
// STRUCTURE
//   Package sm_tri_bus_pkg: state enum {IDLE,REQ,DRIVE,TURN} (2 bits),
//     RX queue depth constant (2).
//   Sub-module sm_tri_bus_rxq: 2-entry val/rdy queue with full/empty and
//     push-drop indication. sm_Buf reused for all bus drivers.
//
// TESTING (two ports id 0/1 on one bus, pull-down on bus_val, bench arbiter)
//   Reset: after reset all bus pins z, tx_rdy=1, arb_req=0, rx_val=0, drops=0.
//   Send: port0 tx_dst=1 tx_msg=8'hA5, gnt next cycle -> bus shows 1/A5 for
//     one cycle, port1 rx_val=1 rx_msg=A5 next cycle, port0 back IDLE in 4.
//   Grant delay: hold arb_gnt=0 5 cycles -> port0 stays REQ, bus z, tx_rdy=0.
//   Address filter: port0 sends dst=2 -> port1 rx_val stays 0; port0 no self-rx.
//   Overflow: 3 msgs to port1 with rx_rdy=0 -> queue holds 1st,2nd; drops=1;
//     with rx_rdy=1 while full -> no drop; 300 drops -> saturates 255.
//   Reset in DRIVE: assert reset during DRIVE -> bus z next edge, state IDLE.

Source files
------------

// File: rtl/sm_tri_bus_pkg.sv
// Shared types and constants for the tristate bus endpoint.
package sm_tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } tx_state_t;

    localparam int RXQ_DEPTH = 2;
    localparam int RXQ_PTR_W = $clog2(RXQ_DEPTH);
    localparam int RXQ_CNT_W = $clog2(RXQ_DEPTH + 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sm_buf.sv
// Tristate buffer: drives the bus when enabled, releases it otherwise.
module sm_Buf #(
    parameter int p_nbits = 1
) (
    input  logic               en,
    input  logic [p_nbits-1:0] in_data,
    output tri   [p_nbits-1:0] out_data
);

    assign out_data = en ? in_data : {p_nbits{1'bz}};

endmodule

// File: rtl/sm_tri_bus_rxq.sv
// Small in-order receive queue; a push into a full queue is accepted only
// when the head leaves in the same cycle, otherwise it is reported as dropped.
module sm_tri_bus_rxq
    import sm_tri_bus_pkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [p_nbits-1:0] push_data,
    input  logic               pop_rdy,
    output logic               out_val,
    output logic [p_nbits-1:0] out_data,
    output logic               drop
);

    logic [p_nbits-1:0]   mem_q [RXQ_DEPTH];
    logic [RXQ_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RXQ_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [RXQ_CNT_W-1:0] count_q, count_d;
    logic                 full, empty, pop, push_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == RXQ_CNT_W'(RXQ_DEPTH));
        pop      = !empty && pop_rdy;
        push_ok  = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    generate
        for (genvar gi = 0; gi < RXQ_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && wr_ptr_q == RXQ_PTR_W'(gi)) mem_q[gi] <= push_data;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_val  = !empty;
    assign out_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sm_tri_bus_port.sv
// Half-duplex endpoint on a shared tristate bus: arbitrated one-cycle
// transmit plus an address-filtered receive queue with a drop counter.
module sm_tri_bus_port
    import sm_tri_bus_pkg::*;
#(
    parameter int p_nbits  = 8,
    parameter int p_idbits = 2,
    parameter int p_id     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_val,
    output logic                tx_rdy,
    input  logic [p_idbits-1:0] tx_dst,
    input  logic [p_nbits-1:0]  tx_msg,
    output logic                arb_req,
    input  logic                arb_gnt,
    inout  wire                 bus_val,
    inout  wire  [p_idbits-1:0] bus_dst,
    inout  wire  [p_nbits-1:0]  bus_data,
    output logic                rx_val,
    input  logic                rx_rdy,
    output logic [p_nbits-1:0]  rx_msg,
    output logic [7:0]          rx_drops
);

    tx_state_t             state_q, state_d;
    logic [p_idbits-1:0]   hold_dst_q, hold_dst_d;
    logic [p_nbits-1:0]    hold_msg_q, hold_msg_d;
    logic                  tx_rdy_q, arb_req_q, drv_en_q;
    logic [7:0]            rx_drops_q, rx_drops_d;
    logic                  rx_push, rx_drop;

    always_comb begin
        state_d    = state_q;
        hold_dst_d = hold_dst_q;
        hold_msg_d = hold_msg_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_val) begin
                    hold_dst_d = tx_dst;
                    hold_msg_d = tx_msg;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ:   if (arb_gnt) state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_TURN;
            ST_TURN:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        rx_drops_d = rx_drop ? sat_inc8(rx_drops_q) : rx_drops_q;
    end

    // Outputs are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_dst_q <= '0;
            hold_msg_q <= '0;
            tx_rdy_q   <= 1'b1;
            arb_req_q  <= 1'b0;
            drv_en_q   <= 1'b0;
            rx_drops_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_dst_q <= hold_dst_d;
            hold_msg_q <= hold_msg_d;
            tx_rdy_q   <= (state_d == ST_IDLE);
            arb_req_q  <= (state_d == ST_REQ) || (state_d == ST_DRIVE);
            drv_en_q   <= (state_d == ST_DRIVE);
            rx_drops_q <= rx_drops_d;
        end
    end

    sm_Buf #(.p_nbits(1)) u_buf_val (
        .en(drv_en_q), .in_data(1'b1), .out_data(bus_val)
    );
    sm_Buf #(.p_nbits(p_idbits)) u_buf_dst (
        .en(drv_en_q), .in_data(hold_dst_q), .out_data(bus_dst)
    );
    sm_Buf #(.p_nbits(p_nbits)) u_buf_data (
        .en(drv_en_q), .in_data(hold_msg_q), .out_data(bus_data)
    );

    // Our own transmission is never looped back into the receive queue.
    assign rx_push = (bus_val == 1'b1) && (bus_dst == p_idbits'(p_id)) && !drv_en_q;

    sm_tri_bus_rxq #(.p_nbits(p_nbits)) u_rxq (
        .clk(clk), .reset(reset),
        .push(rx_push), .push_data(bus_data),
        .pop_rdy(rx_rdy), .out_val(rx_val), .out_data(rx_msg),
        .drop(rx_drop)
    );

    assign tx_rdy   = tx_rdy_q;
    assign arb_req  = arb_req_q;
    assign rx_drops = rx_drops_q;

endmodule

// File: tb/tb_sm_tri_bus_port.sv
// Two endpoints (id 0 and 1) on one pulled-down bus, bench arbiter and a
// queue-based model of each endpoint's receive side.
module tb_sm_tri_bus_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tx_val [2];
    logic       tx_rdy [2];
    logic [1:0] tx_dst [2];
    logic [7:0] tx_msg [2];
    logic       arb_req [2];
    logic       arb_gnt [2];
    logic       rx_val [2];
    logic       rx_rdy [2];
    logic [7:0] rx_msg [2];
    logic [7:0] rx_drops [2];

    // Released bus lines read back as the pull-down value 0.
    tri0       bus_val;
    tri0 [1:0] bus_dst;
    tri0 [7:0] bus_data;

    int checks = 0;
    int failures = 0;

    sm_tri_bus_port #(.p_nbits(8), .p_idbits(2), .p_id(0)) u_p0 (
        .clk(clk), .reset(reset),
        .tx_val(tx_val[0]), .tx_rdy(tx_rdy[0]), .tx_dst(tx_dst[0]), .tx_msg(tx_msg[0]),
        .arb_req(arb_req[0]), .arb_gnt(arb_gnt[0]),
        .bus_val(bus_val), .bus_dst(bus_dst), .bus_data(bus_data),
        .rx_val(rx_val[0]), .rx_rdy(rx_rdy[0]), .rx_msg(rx_msg[0]), .rx_drops(rx_drops[0])
    );

    sm_tri_bus_port #(.p_nbits(8), .p_idbits(2), .p_id(1)) u_p1 (
        .clk(clk), .reset(reset),
        .tx_val(tx_val[1]), .tx_rdy(tx_rdy[1]), .tx_dst(tx_dst[1]), .tx_msg(tx_msg[1]),
        .arb_req(arb_req[1]), .arb_gnt(arb_gnt[1]),
        .bus_val(bus_val), .bus_dst(bus_dst), .bus_data(bus_data),
        .rx_val(rx_val[1]), .rx_rdy(rx_rdy[1]), .rx_msg(rx_msg[1]), .rx_drops(rx_drops[1])
    );

    // ---------------- reference model ----------------
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    int         mdrops [2];
    bit         bus_evt = 1'b0;
    int         evt_src = 0;
    int         evt_dst = 0;
    logic [7:0] evt_msg = 8'h00;

    function automatic int mq_size(input int p);
        return (p == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] mq_head(input int p);
        if (p == 0) return (mq0.size() > 0) ? mq0[0] : 8'h00;
        return (mq1.size() > 0) ? mq1[0] : 8'h00;
    endfunction

    task automatic model_step();
        if (reset) begin
            mq0.delete();
            mq1.delete();
            mdrops[0] = 0;
            mdrops[1] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                int sz;
                bit pop, push;
                sz   = mq_size(p);
                pop  = (sz > 0) && (rx_rdy[p] == 1'b1);
                push = bus_evt && (evt_dst == p) && (evt_src != p);
                if (push && sz == 2 && !pop) begin
                    if (mdrops[p] < 255) mdrops[p]++;
                    push = 1'b0;
                end
                if (pop) begin
                    if (p == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                end
                if (push) begin
                    if (p == 0) mq0.push_back(evt_msg); else mq1.push_back(evt_msg);
                end
            end
        end
    endtask

    initial begin
        mdrops[0] = 0;
        mdrops[1] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- scenario tasks ----------------
    // One full transaction from src; called and returning on a negedge with src idle.
    task automatic send(input int src, input int dst, input logic [7:0] msg,
                        input int delay, input bit pop_at_push);
        bit saved_rdy;
        tx_dst[src] = 2'(dst);
        tx_msg[src] = msg;
        tx_val[src] = 1'b1;
        checks++;
        if (tx_rdy[src] !== 1'b1) begin
            failures++; $display("FAIL send_idle_rdy src=%0d got=%b exp=1", src, tx_rdy[src]);
        end
        @(negedge clk);
        tx_val[src] = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (arb_req[src] !== 1'b1 || tx_rdy[src] !== 1'b0 || bus_val !== 1'b0) begin
                failures++;
                $display("FAIL req_wait src=%0d cyc=%0d got req=%b rdy=%b bus_val=%b exp req=1 rdy=0 bus_val=0",
                         src, i, arb_req[src], tx_rdy[src], bus_val);
            end
            if (i == delay) arb_gnt[src] = 1'b1;
            @(negedge clk);
        end
        arb_gnt[src] = 1'b0;
        checks++;
        if (bus_val !== 1'b1 || bus_dst !== 2'(dst) || bus_data !== msg || arb_req[src] !== 1'b1) begin
            failures++;
            $display("FAIL drive src=%0d got val=%b dst=%0d data=%h req=%b exp val=1 dst=%0d data=%h req=1",
                     src, bus_val, bus_dst, bus_data, arb_req[src], dst, msg);
        end
        bus_evt = 1'b1; evt_src = src; evt_dst = dst; evt_msg = msg;
        saved_rdy = (dst < 2) ? rx_rdy[dst] : 1'b0;
        if (pop_at_push && dst < 2) rx_rdy[dst] = 1'b1;
        @(negedge clk);
        bus_evt = 1'b0;
        if (pop_at_push && dst < 2) rx_rdy[dst] = saved_rdy;
        checks++;
        if (bus_val !== 1'b0 || bus_data !== 8'h00 || arb_req[src] !== 1'b0 || tx_rdy[src] !== 1'b0) begin
            failures++;
            $display("FAIL turn src=%0d got val=%b data=%h req=%b rdy=%b exp val=0 data=00 req=0 rdy=0",
                     src, bus_val, bus_data, arb_req[src], tx_rdy[src]);
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (rx_val[p] !== (mq_size(p) > 0) || (mq_size(p) > 0 && rx_msg[p] !== mq_head(p))
                || rx_drops[p] !== 8'(mdrops[p])) begin
                failures++;
                $display("FAIL rx_state port=%0d got val=%b msg=%h drops=%0d exp val=%0d msg=%h drops=%0d",
                         p, rx_val[p], rx_msg[p], rx_drops[p], mq_size(p) > 0, mq_head(p), mdrops[p]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_rdy[src] !== 1'b1) begin
            failures++; $display("FAIL back_idle src=%0d got=%b exp=1", src, tx_rdy[src]);
        end
        $display("send src=%0d dst=%0d msg=%h delay=%0d pop=%0d", src, dst, msg, delay, pop_at_push);
    endtask

    task automatic drain();
        rx_rdy[0] = 1'b1; rx_rdy[1] = 1'b1;
        repeat (3) @(negedge clk);
        rx_rdy[0] = 1'b0; rx_rdy[1] = 1'b0;
        checks++;
        if (rx_val[0] !== 1'b0 || rx_val[1] !== 1'b0) begin
            failures++; $display("FAIL drain got v0=%b v1=%b exp 0 0", rx_val[0], rx_val[1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_val !== 1'b0 || bus_dst !== 2'd0 || bus_data !== 8'h00) begin
            failures++; $display("FAIL reset_bus got %b/%0d/%h exp 0/0/00", bus_val, bus_dst, bus_data);
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (tx_rdy[p] !== 1'b1 || arb_req[p] !== 1'b0 || rx_val[p] !== 1'b0 || rx_drops[p] !== 8'd0) begin
                failures++;
                $display("FAIL reset_port p=%0d got rdy=%b req=%b rxv=%b drops=%0d exp 1 0 0 0",
                         p, tx_rdy[p], arb_req[p], rx_val[p], rx_drops[p]);
            end
        end
        $display("reset done");
    endtask

    task automatic test_send();
        send(0, 1, 8'hA5, 0, 1'b0);
        checks++;
        if (rx_val[1] !== 1'b1 || rx_msg[1] !== 8'hA5) begin
            failures++; $display("FAIL send_rx got val=%b msg=%h exp 1/a5", rx_val[1], rx_msg[1]);
        end
        drain();
    endtask

    task automatic test_grant_delay();
        send(1, 0, 8'($urandom), 5, 1'b0);
        drain();
    endtask

    task automatic test_filter();
        send(0, 2, 8'h3C, 0, 1'b0);
        send(0, 0, 8'hC3, 1, 1'b0);
        send(1, 3, 8'h77, 0, 1'b0);
        checks++;
        if (rx_val[0] !== 1'b0 || rx_val[1] !== 1'b0) begin
            failures++; $display("FAIL filter got v0=%b v1=%b exp 0 0", rx_val[0], rx_val[1]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] m [3];
        for (int i = 0; i < 3; i++) m[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) send(0, 1, m[i], 0, 1'b0);
        checks++;
        if (rx_drops[1] !== 8'd1 || rx_msg[1] !== m[0]) begin
            failures++; $display("FAIL ovf_first got drops=%0d msg=%h exp 1/%h", rx_drops[1], rx_msg[1], m[0]);
        end
        rx_rdy[1] = 1'b1;
        @(negedge clk);
        rx_rdy[1] = 1'b0;
        checks++;
        if (rx_val[1] !== 1'b1 || rx_msg[1] !== m[1]) begin
            failures++; $display("FAIL ovf_second got val=%b msg=%h exp 1/%h", rx_val[1], rx_msg[1], m[1]);
        end
        send(0, 1, 8'h11, 0, 1'b0);
        send(0, 1, 8'h22, 0, 1'b1);
        checks++;
        if (rx_drops[1] !== 8'd1) begin
            failures++; $display("FAIL full_with_pop got drops=%0d exp 1", rx_drops[1]);
        end
        for (int i = 0; i < 300; i++) send(0, 1, 8'(i), 0, 1'b0);
        checks++;
        if (rx_drops[1] !== 8'd255) begin
            failures++; $display("FAIL drops_saturate got=%0d exp 255", rx_drops[1]);
        end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            rx_rdy[0] = 1'($urandom);
            rx_rdy[1] = 1'($urandom);
            send($urandom_range(0, 1), $urandom_range(0, 3), 8'($urandom),
                 $urandom_range(0, 3), 1'($urandom));
        end
        drain();
    endtask

    task automatic test_reset_drive();
        send(0, 1, 8'h5A, 0, 1'b0);
        tx_dst[0] = 2'd1; tx_msg[0] = 8'hE7; tx_val[0] = 1'b1;
        @(negedge clk);
        tx_val[0] = 1'b0; arb_gnt[0] = 1'b1;
        @(negedge clk);
        arb_gnt[0] = 1'b0;
        checks++;
        if (bus_val !== 1'b1 || bus_data !== 8'hE7) begin
            failures++; $display("FAIL rst_drive_pre got val=%b data=%h exp 1/e7", bus_val, bus_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_val !== 1'b0 || bus_data !== 8'h00 || tx_rdy[0] !== 1'b1 || arb_req[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_drive got val=%b data=%h rdy=%b req=%b exp 0/00/1/0",
                     bus_val, bus_data, tx_rdy[0], arb_req[0]);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_val[1] !== 1'b0 || tx_rdy[0] !== 1'b1 || bus_val !== 1'b0) begin
            failures++;
            $display("FAIL rst_drive_after got rxv=%b rdy=%b val=%b exp 0/1/0", rx_val[1], tx_rdy[0], bus_val);
        end
        $display("reset during drive done");
    endtask

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            tx_val[p] = 1'b0; tx_dst[p] = 2'd0; tx_msg[p] = 8'h00;
            arb_gnt[p] = 1'b0; rx_rdy[p] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_send();
        test_grant_delay();
        test_filter();
        test_overflow();
        test_random();
        test_reset_drive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
